// File: rtl/blit_pixel_writer.sv
// Blitter pixel writer: clips and keys the pixel stream, forms byte addresses,
// coalesces 8bpp pixels into masked 32-bit words and issues single-outstanding writes.
module blit_pixel_writer #(
  parameter int ADDR_W   = 26,
  parameter int STRIDE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coord_busy,
  input  logic                p1_valid,
  input  logic [15:0]         p1_x,
  input  logic [15:0]         p1_y,
  input  logic [7:0]          p1_color,
  output logic                p2_ready,
  input  logic [ADDR_W-1:0]   reg_fb_base,
  input  logic [STRIDE_W-1:0] reg_fb_stride,
  input  logic [15:0]         reg_clip_x1,
  input  logic [15:0]         reg_clip_y1,
  input  logic [15:0]         reg_clip_x2,
  input  logic [15:0]         reg_clip_y2,
  input  logic                reg_trans_en,
  input  logic [7:0]          reg_trans_color,
  output logic                mem_req,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wmask,
  input  logic                mem_ack,
  output logic                idle
);

  localparam int PROD_W = 16 + STRIDE_W;

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_row_q, s1_row_d;
  logic [ADDR_W-1:0] s1_col_q, s1_col_d;
  logic [7:0]        s1_color_q, s1_color_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [7:0]        s2_color_q, s2_color_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-3:0] buf_addr_q, buf_addr_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic [3:0]        buf_mask_q, buf_mask_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;

  logic              pass_s;
  logic              flush_s;
  logic [PROD_W-1:0] row_prod_s;
  logic [ADDR_W-1:0] x_ext_s;

  assign p2_ready   = !(mem_req_q && buf_valid_q);
  assign idle       = !coord_busy && !p1_valid && !s1_valid_q && !s2_valid_q &&
                      !buf_valid_q && !mem_req_q;
  assign pass_s     = p1_valid &&
                      ($signed(p1_x) >= $signed(reg_clip_x1)) && ($signed(p1_x) < $signed(reg_clip_x2)) &&
                      ($signed(p1_y) >= $signed(reg_clip_y1)) && ($signed(p1_y) < $signed(reg_clip_y2)) &&
                      !(reg_trans_en && (p1_color == reg_trans_color));
  assign row_prod_s = PROD_W'(p1_y) * PROD_W'(reg_fb_stride);
  assign x_ext_s    = {{(ADDR_W-16){p1_x[15]}}, p1_x};
  assign flush_s    = !coord_busy && !p1_valid && !s1_valid_q && !s2_valid_q &&
                      buf_valid_q && !mem_req_q;

  // Next-state: pipeline advance, word coalescing, write issue and end-of-stream flush
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_row_d    = s1_row_q;
    s1_col_d    = s1_col_q;
    s1_color_d  = s1_color_q;
    s2_valid_d  = s2_valid_q;
    s2_addr_d   = s2_addr_q;
    s2_color_d  = s2_color_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_mask_d  = buf_mask_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;

    if (mem_req_q && mem_ack) begin
      mem_req_d = 1'b0;
    end else begin
      mem_req_d = mem_req_q;
    end

    if (p2_ready) begin
      s1_valid_d = pass_s;
      s1_row_d   = row_prod_s[ADDR_W-1:0];
      s1_col_d   = reg_fb_base + x_ext_s;
      s1_color_d = p1_color;
      s2_valid_d = s1_valid_q;
      s2_addr_d  = s1_row_q + s1_col_q;
      s2_color_d = s1_color_q;
      if (s2_valid_q) begin
        if (buf_valid_q && (buf_addr_q == s2_addr_q[ADDR_W-1:2])) begin
          buf_data_d[{s2_addr_q[1:0], 3'b000} +: 8] = s2_color_q;
          buf_mask_d[s2_addr_q[1:0]]                = 1'b1;
        end else begin
          // p2_ready with a full buffer implies the write port is free
          if (buf_valid_q) begin
            mem_req_d   = 1'b1;
            mem_addr_d  = buf_addr_q;
            mem_wdata_d = buf_data_q;
            mem_wmask_d = buf_mask_q;
          end else begin
            mem_req_d = mem_req_d;
          end
          buf_valid_d = 1'b1;
          buf_addr_d  = s2_addr_q[ADDR_W-1:2];
          buf_data_d  = 32'h0000_0000;
          buf_data_d[{s2_addr_q[1:0], 3'b000} +: 8] = s2_color_q;
          buf_mask_d  = 4'b0001 << s2_addr_q[1:0];
        end
      end else begin
        buf_valid_d = buf_valid_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (flush_s) begin
      mem_req_d   = 1'b1;
      mem_addr_d  = buf_addr_q;
      mem_wdata_d = buf_data_q;
      mem_wmask_d = buf_mask_q;
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_d;
    end
  end

  // State registers; reset abandons any outstanding request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_color_q  <= 8'h00;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_color_q  <= 8'h00;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= 32'h0000_0000;
      buf_mask_q  <= 4'h0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      mem_wmask_q <= 4'h0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      s1_color_q  <= s1_color_d;
      s2_valid_q  <= s2_valid_d;
      s2_addr_q   <= s2_addr_d;
      s2_color_q  <= s2_color_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_mask_q  <= buf_mask_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule
